// File: rtl/digital_interpolation.sv
`default_nettype none
// ============================================================================
// Module      : digital_interpolation
// Description : Zero-order-hold interpolator. Each accepted input sample is
//               repeated max(factor,1) times on a valid/ready output stream.
//               The first beat of each group is flagged (m_first) and carries
//               per-channel transition flags against the previously accepted
//               sample (m_edge). The last beat is flagged by m_last.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               clear             - synchronous flush of the current group
//               factor            - repeat count, latched at acceptance
//               s_valid/s_ready/s_data   - input sample stream
//               m_valid/m_ready/m_data   - expanded output stream
//               m_first/m_last    - group boundary markers
//               m_edge            - channel transition flags (first beat only)
// Revision    : 1.0 - initial release
// ============================================================================
module digital_interpolation #(
    parameter int WIDTH    = 8,
    parameter int FACTOR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [FACTOR_W-1:0] factor,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WIDTH-1:0]    s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_first,
    output logic                m_last,
    output logic [WIDTH-1:0]    m_edge
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [FACTOR_W-1:0] c_one = {{(FACTOR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [FACTOR_W-1:0] r_cnt;      // beats remaining after the current one
    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_prev;     // previously accepted sample
    logic                r_first;

    logic                w_cnt_zero;
    logic                w_accept;
    logic [FACTOR_W-1:0] w_load_cnt;

    assign w_cnt_zero = (r_cnt == '0);
    assign m_valid    = (r_state == ST_EMIT);

    // A new sample may enter only when nothing is held, or when the final
    // beat of the current group departs in this very cycle.
    assign s_ready    = !clear && (!m_valid || (m_ready && w_cnt_zero));
    assign w_accept   = s_valid && s_ready;

    // factor==0 behaves as factor==1, so both load a zero remaining count.
    assign w_load_cnt = (factor == '0) ? '0 : (factor - c_one);

    assign m_data  = r_data;
    assign m_first = r_first;
    assign m_last  = m_valid && w_cnt_zero;
    assign m_edge  = r_first ? (r_data ^ r_prev) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_prev  <= '0;
            r_first <= 1'b0;
        end else if (clear) begin
            // Any beat handshaken this cycle is considered delivered; the
            // held sample and prev are kept so later edges compare to it.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else if (w_accept) begin
            // Covers both the IDLE start and the back-to-back reload on the
            // final beat; r_data is the sample being retired.
            r_state <= ST_EMIT;
            r_prev  <= r_data;
            r_data  <= s_data;
            r_cnt   <= w_load_cnt;
            r_first <= 1'b1;
        end else if ((r_state == ST_EMIT) && m_ready) begin
            r_first <= 1'b0;
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_one;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digital_interpolation.sv
`default_nettype none
// ============================================================================
// Module      : tb_digital_interpolation
// Description : Self-checking bench for digital_interpolation. A cycle table
//               gives the inputs for each cycle together with the outputs
//               expected in that cycle; a hand-written sequence covers the
//               maximum-factor group.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_interpolation;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [7:0] factor;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_first;
    logic       m_last;
    logic [7:0] m_edge;

    int n_tests;
    int n_fail;

    digital_interpolation #(
        .WIDTH    (8),
        .FACTOR_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .factor  (factor),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_first (m_first),
        .m_last  (m_last),
        .m_edge  (m_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven during the cycle and the
    // outputs expected during that same cycle (before its rising edge).
    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       sv;
        logic [7:0] sd;
        logic [7:0] fac;
        logic       mr;
        logic       chk;
        logic       sr;
        logic       mv;
        logic [7:0] md;
        logic       mf;
        logic       ml;
        logic [7:0] me;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic c, input logic sv,
                       input logic [7:0] sd, input logic [7:0] fac,
                       input logic mr, input logic chk, input logic sr,
                       input logic mv, input logic [7:0] md, input logic mf,
                       input logic ml, input logic [7:0] me);
        vec_t v;
        v.rst = r;  v.clr = c;  v.sv = sv; v.sd = sd; v.fac = fac; v.mr = mr;
        v.chk = chk; v.sr = sr; v.mv = mv; v.md = md; v.mf = mf; v.ml = ml;
        v.me = me;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {sr,mv,md,mf,ml,me}=%05h expected %05h",
                     name, act, exp);
        end
    endtask

    initial begin
        int beats;
        int guard;
        bit saw_last;
        bit first_ok;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; clear = 1'b0; factor = 8'd1; s_valid = 1'b0;
        s_data = 8'h00; m_ready = 1'b1;

        //   rst clr sv sd     fac     mr chk  sr mv md     mf ml me
        // factor 4, single sample A5
        add(0, 0, 1, 8'hA5, 8'd4,   1, 1,  1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd4,   1, 1,  0, 1, 8'hA5, 1, 0, 8'hA5);
        add(0, 0, 0, 8'h00, 8'd4,   1, 1,  0, 1, 8'hA5, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd4,   1, 1,  0, 1, 8'hA5, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd4,   1, 1,  1, 1, 8'hA5, 0, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'd4,   1, 1,  1, 0, 8'hA5, 0, 0, 8'h00);
        // reset, then factor 0 back-to-back 01,03,02
        add(1, 0, 0, 8'h00, 8'd0,   1, 0,  0, 0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 1, 8'h01, 8'd0,   1, 1,  1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 1, 8'h03, 8'd0,   1, 1,  1, 1, 8'h01, 1, 1, 8'h01);
        add(0, 0, 1, 8'h02, 8'd0,   1, 1,  1, 1, 8'h03, 1, 1, 8'h02);
        add(0, 0, 0, 8'h00, 8'd0,   1, 1,  1, 1, 8'h02, 1, 1, 8'h01);
        add(0, 0, 0, 8'h00, 8'd0,   1, 1,  1, 0, 8'h02, 0, 0, 8'h00);
        // factor 3, m_ready toggling
        add(0, 0, 1, 8'h3C, 8'd3,   1, 1,  1, 0, 8'h02, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd3,   1, 1,  0, 1, 8'h3C, 1, 0, 8'h3E);
        add(0, 0, 0, 8'h00, 8'd3,   0, 1,  0, 1, 8'h3C, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd3,   1, 1,  0, 1, 8'h3C, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd3,   0, 1,  0, 1, 8'h3C, 0, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'd3,   1, 1,  1, 1, 8'h3C, 0, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'd3,   0, 1,  1, 0, 8'h3C, 0, 0, 8'h00);
        // factor 5 latched, changed to 2 mid-group; stall on first beat
        add(0, 0, 1, 8'h81, 8'd5,   0, 1,  1, 0, 8'h3C, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd5,   0, 1,  0, 1, 8'h81, 1, 0, 8'hBD);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  0, 1, 8'h81, 1, 0, 8'hBD);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  0, 1, 8'h81, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  0, 1, 8'h81, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  0, 1, 8'h81, 0, 0, 8'h00);
        add(0, 0, 1, 8'h7E, 8'd2,   1, 1,  1, 1, 8'h81, 0, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  0, 1, 8'h7E, 1, 0, 8'hFF);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  1, 1, 8'h7E, 0, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'd2,   1, 1,  1, 0, 8'h7E, 0, 0, 8'h00);
        // factor 6, clear after beat 2 coinciding with a handshake
        add(0, 0, 1, 8'h55, 8'd6,   1, 1,  1, 0, 8'h7E, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd6,   1, 1,  0, 1, 8'h55, 1, 0, 8'h2B);
        add(0, 0, 0, 8'h00, 8'd6,   1, 1,  0, 1, 8'h55, 0, 0, 8'h00);
        add(0, 1, 1, 8'h99, 8'd6,   1, 1,  0, 1, 8'h55, 0, 0, 8'h00);
        add(0, 0, 1, 8'h0F, 8'd1,   1, 1,  1, 0, 8'h55, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd1,   1, 1,  1, 1, 8'h0F, 1, 1, 8'h5A);
        add(0, 0, 0, 8'h00, 8'd1,   1, 1,  1, 0, 8'h0F, 0, 0, 8'h00);
        // factor 255, reset mid-group while a sample is offered
        add(0, 0, 1, 8'hC3, 8'd255, 1, 1,  1, 0, 8'h0F, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd255, 1, 1,  0, 1, 8'hC3, 1, 0, 8'hCC);
        add(1, 0, 1, 8'h11, 8'd255, 1, 1,  0, 1, 8'hC3, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd1,   1, 1,  1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 1, 8'h3A, 8'd1,   1, 1,  1, 0, 8'h00, 0, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'd1,   1, 1,  1, 1, 8'h3A, 1, 1, 8'h3A);
        add(0, 0, 0, 8'h00, 8'd1,   1, 1,  1, 0, 8'h3A, 0, 0, 8'h00);

        // Two reset cycles before the table starts.
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            clear   = vecs[i].clr;
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            factor  = vecs[i].fac;
            m_ready = vecs[i].mr;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("row%0d", i),
                      {s_ready, m_valid, m_data, m_first, m_last, m_edge},
                      {vecs[i].sr, vecs[i].mv, vecs[i].md, vecs[i].mf,
                       vecs[i].ml, vecs[i].me});
            end
        end

        // Maximum factor: exactly 255 beats, no counter wrap.
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'hE7; factor = 8'd255; m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        beats = 0; saw_last = 1'b0; first_ok = 1'b0; guard = 0;
        #1;
        first_ok = m_valid && m_first && (m_edge == (8'hE7 ^ 8'h3A));
        while (!saw_last && guard < 400) begin
            if (m_valid && m_data == 8'hE7) beats++;
            if (m_last) saw_last = 1'b1;
            guard++;
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (!first_ok) begin
            n_fail++;
            $display("FAIL max_first: m_first/m_edge wrong on first beat of 255-group");
        end
        n_tests++;
        if (!saw_last || beats != 255) begin
            n_fail++;
            $display("FAIL max_beats: got %0d beats (last seen=%0d) expected 255",
                     beats, saw_last);
        end
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL max_idle: got m_valid=%0b s_ready=%0b expected 0/1",
                     m_valid, s_ready);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
